uart_mmio_ctrl: RTL

Memory-mapped controller that shares the UART between the CPU's memory stage and the serial link. It decodes loads and stores in the 0x8000_00xx I/O window and buffers TX and RX bytes in small FIFOs, so the CPU only polls status and never stalls. It also drives the UART's ready/valid handshakes. It sits beside data memory, with its rdata selected by the writeback read-data mux.

---
 rtl/uart_mmio_pkg.sv | 35 +++
 rtl/uart_mmio_ctrl_sync_fifo.sv | 46 ++++
 rtl/uart_mmio_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register addresses,
// status bit positions and the address decoder.
package uart_mmio_pkg;

  localparam logic [31:0] UART_TX_STAT = 32'h8000_0000;
  localparam logic [31:0] UART_RX_STAT = 32'h8000_0004;
  localparam logic [31:0] UART_TX_DATA = 32'h8000_0008;
  localparam logic [31:0] UART_RX_DATA = 32'h8000_000C;
  localparam logic [31:0] UART_CYC_CNT = 32'h8000_0010;

  localparam int STAT_RDY_BIT = 0;
  localparam int STAT_OVF_BIT = 1;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_TX_STAT = 3'd1,
    SEL_RX_STAT = 3'd2,
    SEL_TX_DATA = 3'd3,
    SEL_RX_DATA = 3'd4,
    SEL_CYC_CNT = 3'd5
  } reg_sel_e;

  // Full 32-bit compare; anything else is unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] a);
    case (a)
      UART_TX_STAT: decode_addr = SEL_TX_STAT;
      UART_RX_STAT: decode_addr = SEL_RX_STAT;
      UART_TX_DATA: decode_addr = SEL_TX_DATA;
      UART_RX_DATA: decode_addr = SEL_RX_DATA;
      UART_CYC_CNT: decode_addr = SEL_CYC_CNT;
      default:      decode_addr = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Pop of an empty FIFO is ignored;
// a push while full is taken only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller with TX/RX byte FIFOs and registered rdata.
// Optional free-running cycle counter at 0x8000_0010 under UART_MMIO_CYCLE_CNT_EN.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  reg_sel_e    w_sel;
  logic        w_rd_only;
  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [31:0] w_rd_val;
  logic [31:0] w_cyc_val;
  logic        w_unused;
  logic        r_tx_ovf;
  logic [31:0] r_rdata;

  assign w_sel     = decode_addr(addr);
  assign w_rd_only = re && !we;
  assign w_unused  = ^wdata[31:8];

  assign w_tx_push = we && (w_sel == SEL_TX_DATA);
  assign w_tx_pop  = tx_ready && !w_tx_empty;
  assign tx_valid  = !w_tx_empty;

  assign rx_ready  = !rst && !w_rx_full;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = w_rd_only && (w_sel == SEL_RX_DATA) && !w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .din(wdata[7:0]),
    .full(w_tx_full), .empty(w_tx_empty), .head(tx_data)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop), .din(rx_data),
    .full(w_rx_full), .empty(w_rx_empty), .head(w_rx_head)
  );

`ifdef UART_MMIO_CYCLE_CNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_cyc_cnt <= 32'd0;
    else if (we && (w_sel == SEL_CYC_CNT)) r_cyc_cnt <= 32'd0;
    else                                   r_cyc_cnt <= r_cyc_cnt + 32'd1;
  end

  assign w_cyc_val = r_cyc_cnt;
`else
  assign w_cyc_val = 32'd0;
`endif

  always_comb begin
    w_rd_val = 32'd0;
    case (w_sel)
      SEL_TX_STAT: begin
        w_rd_val[STAT_RDY_BIT] = !w_tx_full;
        w_rd_val[STAT_OVF_BIT] = r_tx_ovf;
      end
      SEL_RX_STAT: w_rd_val[STAT_RDY_BIT] = !w_rx_empty;
      SEL_RX_DATA: w_rd_val = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      SEL_CYC_CNT: w_rd_val = w_cyc_val;
      default:     w_rd_val = 32'd0;
    endcase
  end

  // A dropped push sets the flag; a concurrent status read still sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_tx_ovf <= 1'b0;
    else if (w_tx_push && w_tx_full && !w_tx_pop)     r_tx_ovf <= 1'b1;
    else if (w_rd_only && (w_sel == SEL_TX_STAT))     r_tx_ovf <= 1'b0;
    else                                              r_tx_ovf <= r_tx_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_rdata <= 32'd0;
    else if (re) r_rdata <= we ? 32'd0 : w_rd_val;
    else         r_rdata <= r_rdata;
  end

  assign rdata = r_rdata;

endmodule
